ascii_ps2_tx: RTL

ASCII_PS2_TX -- requirements
Module: ascii_ps2_tx

---
 rtl/ascii_ps2_tx_if.sv | 20 ++
 rtl/ascii_ps2_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ascii_ps2_tx_if.sv
// Request/status and PS/2 line bundle for ascii_ps2_tx.
interface ascii_ps2_tx_if;
  logic [6:0] ascii;
  logic       send;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output ascii, send,
    input  ps2_clk, ps2_data, busy, done, err
  );

  modport slave (
    input  ascii, send,
    output ps2_clk, ps2_data, busy, done, err
  );
endinterface

// File: rtl/ascii_ps2_tx.sv
// ASCII letter to PS/2 set-2 keystroke sequence transmitter (device side).
// Lowercase letters emit make/F0/make; uppercase wraps the key in left shift.
module ascii_ps2_tx #(
  parameter int unsigned HALF_PERIOD = 4000,
  parameter int unsigned GAP_CYCLES  = 8000
) (
  input  logic           clk,
  input  logic           reset,
  ascii_ps2_tx_if.slave  bus
);

  localparam int unsigned HW       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_STAY = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  // GAP is one cycle short so that GAP plus the following LOAD give exactly
  // GAP_CYCLES idle cycles between the end of one frame and the next start bit.
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_STAY);

  typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, GAP, FIN} state_t;

  state_t       state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]   bit_q, bit_d;
  logic [2:0]   byte_q, byte_d;
  logic [7:0]   make_q, make_d;
  logic         upper_q, upper_d;
  logic [10:0]  frame_q, frame_d;
  logic         err_q, err_d;

  logic         is_lower, is_upper;
  logic [7:0]   cur_byte;
  logic [2:0]   last_byte;

  // Set-2 make code for a letter, either case; 00 for anything else.
  function automatic logic [7:0] make_code(input logic [6:0] c);
    logic [7:0] m;
    case (c)
      7'd97,  7'd65: m = 8'h1C;
      7'd98,  7'd66: m = 8'h32;
      7'd99,  7'd67: m = 8'h21;
      7'd100, 7'd68: m = 8'h23;
      7'd101, 7'd69: m = 8'h24;
      7'd102, 7'd70: m = 8'h2B;
      7'd103, 7'd71: m = 8'h34;
      7'd104, 7'd72: m = 8'h33;
      7'd105, 7'd73: m = 8'h43;
      7'd106, 7'd74: m = 8'h3B;
      7'd107, 7'd75: m = 8'h42;
      7'd108, 7'd76: m = 8'h4B;
      7'd109, 7'd77: m = 8'h3A;
      7'd110, 7'd78: m = 8'h31;
      7'd111, 7'd79: m = 8'h44;
      7'd112, 7'd80: m = 8'h4D;
      7'd113, 7'd81: m = 8'h15;
      7'd114, 7'd82: m = 8'h2D;
      7'd115, 7'd83: m = 8'h1B;
      7'd116, 7'd84: m = 8'h2C;
      7'd117, 7'd85: m = 8'h3C;
      7'd118, 7'd86: m = 8'h2A;
      7'd119, 7'd87: m = 8'h1D;
      7'd120, 7'd88: m = 8'h22;
      7'd121, 7'd89: m = 8'h35;
      7'd122, 7'd90: m = 8'h1A;
      default:       m = 8'h00;
    endcase
    return m;
  endfunction

  // Byte at position idx of the keystroke sequence.
  function automatic logic [7:0] seq_byte(input logic [2:0] idx, input logic up,
                                          input logic [7:0] mk);
    logic [7:0] b;
    if (up) begin
      case (idx)
        3'd0:    b = 8'h12;
        3'd1:    b = mk;
        3'd2:    b = 8'hF0;
        3'd3:    b = mk;
        3'd4:    b = 8'hF0;
        default: b = 8'h12;
      endcase
    end else begin
      case (idx)
        3'd1:    b = 8'hF0;
        default: b = mk;
      endcase
    end
    return b;
  endfunction

  assign is_lower  = (bus.ascii >= 7'd97) && (bus.ascii <= 7'd122);
  assign is_upper  = (bus.ascii >= 7'd65) && (bus.ascii <= 7'd90);
  assign cur_byte  = seq_byte(byte_q, upper_q, make_q);
  assign last_byte = upper_q ? 3'd5 : 3'd2;

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      half_q  <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      make_q  <= '0;
      upper_q <= 1'b0;
      frame_q <= '1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      make_q  <= make_d;
      upper_q <= upper_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept, frame load, bit timing, inter-byte gap.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    make_d  = make_q;
    upper_d = upper_q;
    frame_d = frame_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.send) begin
          if (is_lower || is_upper) begin
            make_d  = make_code(bus.ascii);
            upper_d = is_upper;
            byte_d  = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        frame_d = {1'b1, ~^cur_byte, cur_byte, 1'b0};
        bit_d   = '0;
        half_d  = '0;
        state_d = BIT_HI;
      end
      BIT_HI: begin
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          state_d = BIT_LO;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      BIT_LO: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (bit_q == 4'd10) begin
            if (byte_q == last_byte) begin
              state_d = FIN;
            end else begin
              byte_d  = byte_q + 3'd1;
              gap_d   = '0;
              state_d = GAP;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = BIT_HI;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = LOAD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ps2_clk  = (state_q != BIT_LO);
  assign bus.ps2_data = (state_q == BIT_HI || state_q == BIT_LO) ? frame_q[bit_q] : 1'b1;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == FIN);
  assign bus.err      = err_q;

endmodule
